// File: rtl/hangman_pkg.sv
// Shared definitions for the Hangman round controller and its consumers.
// - Game state encoding (also consumed by the status display).
// - key_w(): width of the keypad code bus, wide enough for letters 0..N_SYM-1
//   plus the start/restart code N_SYM.
package hangman_pkg;

    localparam logic [1:0] GS_START    = 2'd0;
    localparam logic [1:0] GS_INGAME   = 2'd1;
    localparam logic [1:0] GS_WINGAME  = 2'd2;
    localparam logic [1:0] GS_LOSTGAME = 2'd3;

    typedef enum logic [1:0] {
        START    = GS_START,
        INGAME   = GS_INGAME,
        WINGAME  = GS_WINGAME,
        LOSTGAME = GS_LOSTGAME
    } game_state_e;

    function automatic int key_w(input int n_sym);
        return $clog2(n_sym + 1);
    endfunction

endpackage

// File: rtl/hangman_sat_counter.sv
// Saturating up-counter used for the win and loss tallies.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high; clears the count
//   inc    - increment request (ignored once the count is all-ones)
//   count  - current tally
module hangman_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: sequences START -> INGAME -> WINGAME/LOSTGAME.
// The word's letter mask is latched on a start; keypad strobes then guess
// letters. Repeated guesses are flagged and cost nothing; a start code during
// a round aborts it (not tallied). All outputs are registered, latency 1.
// Ports:
//   clk, reset    - clock, synchronous active-high reset (wins over load)
//   load, load_x  - one-cycle key strobe and key code (START_CODE = start)
//   mask          - letters present in the word, sampled only on a start
//   guessed_mask  - correctly guessed letters
//   tried_mask    - every letter tried this round
//   game_state    - START/INGAME/WINGAME/LOSTGAME
//   wrong         - pulse: new miss
//   repeat_guess  - pulse: letter already tried
//   lives_left    - remaining lives
//   wins, losses  - saturating round tallies
module hangman_round_ctrl
    import hangman_pkg::*;
#(
    parameter int N_SYM      = 26,
    parameter int START_CODE = N_SYM,
    parameter int LIVES      = 5,
    parameter int LW         = $clog2(LIVES + 1),
    parameter int SCORE_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [key_w(N_SYM)-1:0]    load_x,
    input  logic [N_SYM-1:0]           mask,
    output logic [N_SYM-1:0]           guessed_mask,
    output logic [N_SYM-1:0]           tried_mask,
    output logic [1:0]                 game_state,
    output logic                       wrong,
    output logic                       repeat_guess,
    output logic [LW-1:0]              lives_left,
    output logic [SCORE_W-1:0]         wins,
    output logic [SCORE_W-1:0]         losses
);

    localparam int KW = key_w(N_SYM);

    game_state_e      state_q;
    logic [N_SYM-1:0] word_q, guessed_q, tried_q;
    logic [LW-1:0]    lives_q;
    logic             wrong_q, rep_q;

    logic [N_SYM-1:0] x_oh;
    logic             in_range, is_start, is_tried, is_hit;
    logic             new_guess, win_ev, loss_ev;

    // One-hot of the key code; all-zero for non-letter codes.
    always_comb begin
        x_oh = '0;
        for (int i = 0; i < N_SYM; i++) begin
            x_oh[i] = (load_x == KW'(i));
        end
    end

    assign in_range  = (load_x < KW'(N_SYM));
    assign is_start  = (load_x == KW'(START_CODE));
    assign is_tried  = |(tried_q & x_oh);
    assign is_hit    = |(word_q & x_oh);
    assign new_guess = load && (state_q == INGAME) && in_range && !is_tried;
    // Win when this hit completes the latched word.
    assign win_ev    = new_guess && is_hit && ((guessed_q | x_oh) == word_q);
    // Loss when a miss lands on the last life.
    assign loss_ev   = new_guess && !is_hit && (lives_q == LW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= START;
            word_q    <= '0;
            guessed_q <= '0;
            tried_q   <= '0;
            lives_q   <= LW'(LIVES);
            wrong_q   <= 1'b0;
            rep_q     <= 1'b0;
        end else begin
            wrong_q <= 1'b0;
            rep_q   <= 1'b0;
            if (load) begin
                if (state_q == INGAME && in_range) begin
                    if (is_tried) begin
                        rep_q <= 1'b1;
                    end else begin
                        tried_q <= tried_q | x_oh;
                        if (is_hit) begin
                            guessed_q <= guessed_q | x_oh;
                            if (win_ev) state_q <= WINGAME;
                        end else begin
                            wrong_q <= 1'b1;
                            lives_q <= lives_q - LW'(1);
                            if (loss_ev) state_q <= LOSTGAME;
                        end
                    end
                end else if (is_start) begin
                    if (mask != '0) begin
                        word_q    <= mask;
                        guessed_q <= '0;
                        tried_q   <= '0;
                        lives_q   <= LW'(LIVES);
                        state_q   <= INGAME;
                    end else if (state_q == INGAME) begin
                        // Abort with an empty word: drop back to idle,
                        // round status left as it was.
                        state_q <= START;
                    end
                end
            end
        end
    end

    hangman_sat_counter #(.W(SCORE_W)) u_wins (
        .clk  (clk),
        .reset(reset),
        .inc  (win_ev),
        .count(wins)
    );

    hangman_sat_counter #(.W(SCORE_W)) u_losses (
        .clk  (clk),
        .reset(reset),
        .inc  (loss_ev),
        .count(losses)
    );

    assign game_state   = state_q;
    assign guessed_mask = guessed_q;
    assign tried_mask   = tried_q;
    assign lives_left   = lives_q;
    assign wrong        = wrong_q;
    assign repeat_guess = rep_q;

endmodule
